pico_qsys_pio_master: RTL and testbench
=======================================

# pico_qsys_pio_master

Avalon-MM initiator that drives a register-mapped PIO-style slave on the pico Qsys fabric: chipselect / write_n / 2-bit word address, with no waitrequest and a fixed read latency. A local command port (req/ready in, one-cycle response pulse out) is converted into single bus writes, single reads, or atomic read-modify-write bit set/clear sequences. The block sits between a local controller and one PIO slave such as an LED or GPIO port.

## Interface
- READ_LATENCY, 0, cycles from the first chipselect cycle of a read to valid `avm_readdata`; legal range 0–3. Use 0 for PIO slaves.

- clk  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle; command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 WRITE, 01 READ, 10 SET (RMW OR), 11 CLEAR (RMW AND-NOT)
- cmd_address  in  2  slave word address
- cmd_data  in  32  write data (WRITE) or bit mask (SET/CLEAR); ignored for READ
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_data  out  32  read value (READ), pre-modify value (SET/CLEAR), 0 (WRITE)
- avm_address  out  2  slave address
- avm_chipselect  out  1  slave select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  32  slave write data
- avm_readdata  in  32  slave read data

## Operation
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0; FSM in IDLE.
- States: IDLE, RD, WR, RSP.
  - IDLE: cmd_ready=1. On accept, cmd_op, cmd_address and cmd_data are captured.
    - WRITE goes to WR.
    - READ, SET and CLEAR go to RD.
  - RD: avm_chipselect=1, avm_write_n=1, avm_address=captured address.
    - Held for READ_LATENCY+1 cycles; a down-counter tracks the cycles.
    - avm_readdata is captured at the end of the last RD cycle.
    - READ then goes to RSP.
    - SET/CLEAR then go to WR with writedata = rd | mask (SET) or rd & ~mask (CLEAR).
  - WR: avm_chipselect=1, avm_write_n=0 for exactly one cycle, avm_writedata valid. Then goes to RSP.
  - RSP: rsp_valid=1 for one cycle, rsp_data per cmd_op. Then goes to IDLE.
- When avm_chipselect=0, avm_write_n=1 and avm_address/avm_writedata are 0.
- All outputs are registered. No combinational path from cmd_* or avm_readdata to any output.
- cmd_ready=0 in every state except IDLE. cmd_valid held high while busy is not sampled and causes no duplicate transaction.
- rsp_data holds its value until the next RSP.
- An RMW sequence is never interleaved with another command. Chipselect drops for no cycle between the RD and WR phases of a SET/CLEAR.
- Reset mid-operation: the bus returns to its idle values immediately (asynchronously). The command is dropped, no rsp_valid is produced, and the FSM comes up in IDLE.

## Timing
- Command accepted at edge of cycle T (cycle with cmd_valid && cmd_ready); L = READ_LATENCY.
- WRITE:
  - WR at T+1.
  - rsp_valid at T+2.
  - cmd_ready high again at T+3.
- READ:
  - RD during T+1 … T+1+L.
  - rsp_valid at T+2+L.
  - cmd_ready high at T+3+L.
- SET/CLEAR:
  - RD during T+1 … T+1+L.
  - WR at T+2+L.
  - rsp_valid at T+3+L.
  - cmd_ready high at T+4+L.
- Back-to-back commands: minimum issue interval is 3 cycles (WRITE), 3+L (READ), 4+L (RMW).

## Test plan
- Reset, then READ addr 0 against a PIO model (reset value 0xAA, L=0) -> idle bus values during reset; chipselect=1, write_n=1 at T+1; rsp_valid at T+2 with rsp_data=0x000000AA.
- WRITE addr 0 data 0x55 -> chipselect=1, write_n=0, writedata=0x55 for exactly T+1; rsp_valid at T+2 with rsp_data=0; a following READ returns 0x55.
- SET mask 0x0F on 0x55 -> read at T+1, write 0x5F at T+2, rsp_data=0x55 at T+3; then CLEAR mask 0xF0 -> writes 0x0F, rsp_data=0x5F.
- READ_LATENCY=2 slave model (data valid 2 cycles after select) -> chipselect held T+1 … T+3, rsp_valid at T+4 with correct data; data presented earlier is not captured.
- cmd_valid held high continuously with WRITE ops -> one accept every 3 cycles; cmd_ready low for exactly 2 cycles after each accept; one write_n pulse per accept.
- reset_n asserted during the RD phase of a SET -> chipselect drops without waiting for clk, no WR phase, no rsp_valid; after release cmd_ready=1 and the slave keeps its pre-command value.

Source files
------------

// File: rtl/pico_qsys_pio_master.sv
// Avalon-MM initiator for a register-mapped PIO slave: single writes, single reads
// and atomic read-modify-write bit set/clear, all outputs registered.
module pico_qsys_pio_master #(
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_address,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [1:0] LAT      = 2'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] wdata_q, wdata_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        avm_cs_q, avm_cs_d;
  logic        avm_write_n_q, avm_write_n_d;
  logic [1:0]  avm_address_q, avm_address_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d   = cmd_op;
          addr_d = cmd_address;
          data_d = cmd_data;
          if (cmd_op == OP_WRITE) begin
            state_d = WR;
            wdata_d = cmd_data;
          end else begin
            state_d = RD;
            cnt_d   = LAT;
          end
        end
      end
      RD: begin
        if (cnt_q == 2'd0) begin
          rd_d = avm_readdata;
          unique case (op_q)
            OP_SET: begin
              state_d = WR;
              wdata_d = avm_readdata | data_q;
            end
            OP_CLEAR: begin
              state_d = WR;
              wdata_d = avm_readdata & ~data_q;
            end
            default: begin
              state_d     = RSP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = avm_readdata;
            end
          endcase
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      WR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = (op_q == OP_WRITE) ? '0 : rd_q;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus outputs follow the next state so they are registered yet aligned with it;
    // RD->WR keeps chipselect high with no gap.
    cmd_ready_d     = (state_d == IDLE);
    avm_cs_d        = (state_d == RD) || (state_d == WR);
    avm_write_n_d   = (state_d != WR);
    avm_address_d   = avm_cs_d ? addr_d : '0;
    avm_writedata_d = (state_d == WR) ? wdata_d : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      op_q            <= OP_READ;
      addr_q          <= '0;
      data_q          <= '0;
      cnt_q           <= '0;
      rd_q            <= '0;
      wdata_q         <= '0;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      avm_cs_q        <= 1'b0;
      avm_write_n_q   <= 1'b1;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      cnt_q           <= cnt_d;
      rd_q            <= rd_d;
      wdata_q         <= wdata_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      avm_cs_q        <= avm_cs_d;
      avm_write_n_q   <= avm_write_n_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign avm_chipselect = avm_cs_q;
  assign avm_write_n    = avm_write_n_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;

endmodule

// File: tb/tb_pico_qsys_pio_master.sv
// Directed bench: two masters (latency 0 and 2) each driving a small PIO slave model.
module tb_pico_qsys_pio_master;

  logic        clk;
  logic        reset_n;
  logic        slv_init;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_data;

  logic        a_valid, a_ready, a_rsp_valid, a_cs, a_wn;
  logic [31:0] a_rsp_data, a_wdata, a_rdata;
  logic [1:0]  a_addr;

  logic        b_valid, b_ready, b_rsp_valid, b_cs, b_wn;
  logic [31:0] b_rsp_data, b_wdata, b_rdata;
  logic [1:0]  b_addr;

  int checks   = 0;
  int failures = 0;

  pico_qsys_pio_master #(.READ_LATENCY(0)) u_dut_a (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (a_valid),
    .cmd_ready      (a_ready),
    .cmd_op         (cmd_op),
    .cmd_address    (cmd_address),
    .cmd_data       (cmd_data),
    .rsp_valid      (a_rsp_valid),
    .rsp_data       (a_rsp_data),
    .avm_address    (a_addr),
    .avm_chipselect (a_cs),
    .avm_write_n    (a_wn),
    .avm_writedata  (a_wdata),
    .avm_readdata   (a_rdata)
  );

  pico_qsys_pio_master #(.READ_LATENCY(2)) u_dut_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (b_valid),
    .cmd_ready      (b_ready),
    .cmd_op         (cmd_op),
    .cmd_address    (cmd_address),
    .cmd_data       (cmd_data),
    .rsp_valid      (b_rsp_valid),
    .rsp_data       (b_rsp_data),
    .avm_address    (b_addr),
    .avm_chipselect (b_cs),
    .avm_write_n    (b_wn),
    .avm_writedata  (b_wdata),
    .avm_readdata   (b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave A: zero-latency PIO, register 0 resets to 0xAA.
  logic [31:0] sa_regs [4];
  int          a_rsp_cnt;
  always @(posedge clk) begin
    if (slv_init) begin
      sa_regs[0] <= 32'h0000_00AA;
      sa_regs[1] <= 32'h0;
      sa_regs[2] <= 32'h0;
      sa_regs[3] <= 32'h0;
      a_rsp_cnt  <= 0;
    end else begin
      if (a_cs && !a_wn) sa_regs[a_addr] <= a_wdata;
      if (a_rsp_valid) a_rsp_cnt <= a_rsp_cnt + 1;
    end
  end
  always_comb a_rdata = a_cs ? sa_regs[a_addr] : 32'h0;

  // Slave B: data only valid from the third consecutive chipselect cycle.
  logic [31:0] sb_regs [4];
  logic [1:0]  sb_sel;
  always @(posedge clk) begin
    if (slv_init) begin
      sb_regs[0] <= 32'h0;
      sb_regs[1] <= 32'h1234_5678;
      sb_regs[2] <= 32'h0;
      sb_regs[3] <= 32'h0;
    end else if (b_cs && !b_wn) begin
      sb_regs[b_addr] <= b_wdata;
    end
    if (!b_cs) sb_sel <= 2'd0;
    else if (sb_sel != 2'd3) sb_sel <= sb_sel + 2'd1;
  end
  always_comb b_rdata = (b_cs && sb_sel >= 2'd2) ? sb_regs[b_addr] : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue_a(input logic [1:0] op, input logic [1:0] addr, input logic [31:0] data);
    cmd_op      = op;
    cmd_address = addr;
    cmd_data    = data;
    a_valid     = 1'b1;
    tick();
    a_valid     = 1'b0;
  endtask

  int accepts;
  int pulses;
  int rsp_before;

  initial begin
    reset_n     = 1'b0;
    slv_init    = 1'b1;
    a_valid     = 1'b0;
    b_valid     = 1'b0;
    cmd_op      = 2'b00;
    cmd_address = 2'd0;
    cmd_data    = 32'h0;
    tick();
    tick();

    chk("rst_cmd_ready", {31'h0, a_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    chk("rst_rsp_data", a_rsp_data, 32'h0);
    chk("rst_cs", {31'h0, a_cs}, 32'h0);
    chk("rst_write_n", {31'h0, a_wn}, 32'h1);
    chk("rst_addr", {30'h0, a_addr}, 32'h0);
    chk("rst_wdata", a_wdata, 32'h0);

    reset_n  = 1'b1;
    slv_init = 1'b0;
    tick();

    // READ addr 0 -> 0xAA
    issue_a(2'b01, 2'd0, 32'hFFFF_FFFF);
    chk("rd_t1_cs", {31'h0, a_cs}, 32'h1);
    chk("rd_t1_wn", {31'h0, a_wn}, 32'h1);
    chk("rd_t1_ready", {31'h0, a_ready}, 32'h0);
    chk("rd_t1_rspv", {31'h0, a_rsp_valid}, 32'h0);
    tick();
    chk("rd_t2_rspv", {31'h0, a_rsp_valid}, 32'h1);
    chk("rd_t2_data", a_rsp_data, 32'h0000_00AA);
    chk("rd_t2_cs", {31'h0, a_cs}, 32'h0);
    tick();
    chk("rd_t3_rspv", {31'h0, a_rsp_valid}, 32'h0);
    chk("rd_t3_ready", {31'h0, a_ready}, 32'h1);
    chk("rd_t3_hold", a_rsp_data, 32'h0000_00AA);

    // WRITE addr 0 data 0x55
    issue_a(2'b00, 2'd0, 32'h0000_0055);
    chk("wr_t1_cs", {31'h0, a_cs}, 32'h1);
    chk("wr_t1_wn", {31'h0, a_wn}, 32'h0);
    chk("wr_t1_wdata", a_wdata, 32'h0000_0055);
    chk("wr_t1_addr", {30'h0, a_addr}, 32'h0);
    tick();
    chk("wr_t2_cs", {31'h0, a_cs}, 32'h0);
    chk("wr_t2_wn", {31'h0, a_wn}, 32'h1);
    chk("wr_t2_wdata", a_wdata, 32'h0);
    chk("wr_t2_rspv", {31'h0, a_rsp_valid}, 32'h1);
    chk("wr_t2_data", a_rsp_data, 32'h0);
    tick();
    chk("wr_t3_ready", {31'h0, a_ready}, 32'h1);

    issue_a(2'b01, 2'd0, 32'h0);
    tick();
    chk("rd55_rspv", {31'h0, a_rsp_valid}, 32'h1);
    chk("rd55_data", a_rsp_data, 32'h0000_0055);
    tick();

    // WRITE addr 2 shows address on bus
    issue_a(2'b00, 2'd2, 32'h0000_1234);
    chk("wr2_addr", {30'h0, a_addr}, 32'h2);
    tick();
    chk("wr2_addr_idle", {30'h0, a_addr}, 32'h0);
    tick();
    chk("wr2_slave", sa_regs[2], 32'h0000_1234);

    // SET mask 0x0F on 0x55
    issue_a(2'b10, 2'd0, 32'h0000_000F);
    chk("set_t1_cs", {31'h0, a_cs}, 32'h1);
    chk("set_t1_wn", {31'h0, a_wn}, 32'h1);
    tick();
    chk("set_t2_cs", {31'h0, a_cs}, 32'h1);
    chk("set_t2_wn", {31'h0, a_wn}, 32'h0);
    chk("set_t2_wdata", a_wdata, 32'h0000_005F);
    chk("set_t2_rspv", {31'h0, a_rsp_valid}, 32'h0);
    tick();
    chk("set_t3_rspv", {31'h0, a_rsp_valid}, 32'h1);
    chk("set_t3_data", a_rsp_data, 32'h0000_0055);
    chk("set_t3_cs", {31'h0, a_cs}, 32'h0);
    tick();
    chk("set_t4_ready", {31'h0, a_ready}, 32'h1);

    // CLEAR mask 0xF0 on 0x5F
    issue_a(2'b11, 2'd0, 32'h0000_00F0);
    tick();
    chk("clr_t2_wn", {31'h0, a_wn}, 32'h0);
    chk("clr_t2_wdata", a_wdata, 32'h0000_000F);
    tick();
    chk("clr_t3_rspv", {31'h0, a_rsp_valid}, 32'h1);
    chk("clr_t3_data", a_rsp_data, 32'h0000_005F);
    tick();
    chk("clr_slave", sa_regs[0], 32'h0000_000F);

    // READ_LATENCY=2 master
    cmd_op      = 2'b01;
    cmd_address = 2'd1;
    cmd_data    = 32'h0;
    b_valid     = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("l2_t1_cs", {31'h0, b_cs}, 32'h1);
    chk("l2_t1_addr", {30'h0, b_addr}, 32'h1);
    tick();
    chk("l2_t2_cs", {31'h0, b_cs}, 32'h1);
    chk("l2_t2_rspv", {31'h0, b_rsp_valid}, 32'h0);
    tick();
    chk("l2_t3_cs", {31'h0, b_cs}, 32'h1);
    chk("l2_t3_rspv", {31'h0, b_rsp_valid}, 32'h0);
    tick();
    chk("l2_t4_cs", {31'h0, b_cs}, 32'h0);
    chk("l2_t4_rspv", {31'h0, b_rsp_valid}, 32'h1);
    chk("l2_t4_data", b_rsp_data, 32'h1234_5678);
    tick();
    chk("l2_t5_ready", {31'h0, b_ready}, 32'h1);

    // cmd_valid held high with WRITEs
    cmd_op      = 2'b00;
    cmd_address = 2'd3;
    cmd_data    = 32'h0000_0077;
    a_valid     = 1'b1;
    accepts     = 0;
    pulses      = 0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("hold_ready_%0d", i), {31'h0, a_ready}, ((i % 3) == 0) ? 32'h1 : 32'h0);
      if (a_ready && a_valid) accepts++;
      if (a_cs && !a_wn) pulses++;
      tick();
    end
    a_valid = 1'b0;
    chk("hold_accepts", accepts, 32'd3);
    chk("hold_pulses", pulses, 32'd3);
    tick();
    tick();
    tick();

    // reset during RD phase of a SET
    rsp_before = a_rsp_cnt;
    issue_a(2'b10, 2'd0, 32'h0000_00F0);
    chk("rmw_rst_rd_cs", {31'h0, a_cs}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rmw_rst_async_cs", {31'h0, a_cs}, 32'h0);
    chk("rmw_rst_async_wn", {31'h0, a_wn}, 32'h1);
    chk("rmw_rst_async_ready", {31'h0, a_ready}, 32'h1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("rmw_rel_ready", {31'h0, a_ready}, 32'h1);
    chk("rmw_rel_cs", {31'h0, a_cs}, 32'h0);
    tick();
    tick();
    chk("rmw_no_rsp", a_rsp_cnt, rsp_before);
    chk("rmw_slave_kept", sa_regs[0], 32'h0000_000F);

    issue_a(2'b01, 2'd0, 32'h0);
    tick();
    chk("post_rst_rd", a_rsp_data, 32'h0000_000F);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
